// File: rtl/sram_port_pkg.sv
// sram_port_pkg: shared types for the SRAM port master and its response FIFO.
// Holds the controller state encoding. There are no ports.
package sram_port_pkg;
   typedef enum logic {S_INIT, S_RUN} state_t;
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: 2-entry read-response FIFO with occupancy count, no bypass.
// Ports: clk, rst_n (async active-low) | push_i/data_i write side |
//        pop_i/data_o read side | count_o occupancy (0..2).
module sram_rsp_fifo #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic [1:0]   count_o
);
   logic [W-1:0] r_mem [2];
   logic         r_rd, r_wr;
   logic [1:0]   r_count;
   logic         w_push, w_pop;
   assign w_push  = push_i && r_count != 2'd2;
   assign w_pop   = pop_i && r_count != 2'd0;
   assign data_o  = r_mem[r_rd];
   assign count_o = r_count;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd     <= 1'b0;
         r_wr     <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= data_i;
            r_wr        <= ~r_wr;
         end
         if (w_pop) r_rd <= ~r_rd;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end
endmodule

// File: rtl/sram_port_master.sv
// sram_port_master: requester-side controller for one port of a 1-cycle-latency SRAM.
// Ports: clk, rst_n (async active-low) | req_* valid/ready request stream |
//        rsp_* valid/ready read-response stream | flush_i re-initialise pulse |
//        init_done_o high when serving requests | sram_* SRAM port strobes/data.
module sram_port_master
   import sram_port_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DATA_DEPTH = 1024,
   parameter int                    BYTE_SIZE  = 8,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
   localparam int                   ADDR_W     = $clog2(DATA_DEPTH),
   localparam int                   NB         = DATA_WIDTH / BYTE_SIZE
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_W-1:0]     req_addr_i,
   input  logic [NB-1:0]         req_we_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   input  logic                  flush_i,
   output logic                  init_done_o,
   output logic                  sram_en_o,
   output logic [NB-1:0]         sram_we_o,
   output logic [ADDR_W-1:0]     sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_wdata_o,
   input  logic [DATA_WIDTH-1:0] sram_rdata_i
);
   typedef struct packed {
      logic [ADDR_W-1:0]     addr;
      logic [NB-1:0]         we;
      logic [DATA_WIDTH-1:0] wdata;
   } req_t;
   state_t                r_state, w_state_nxt;
   logic [ADDR_W-1:0]     r_init_ptr;
   logic                  r_flush_pending, r_inflight;
   logic [1:0]            w_count;
   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_empty, w_accept, w_push, w_pop, w_last;
   logic [2:0]            w_occ;
   req_t                  w_req;
   assign w_req       = '{addr: req_addr_i, we: req_we_i, wdata: req_wdata_i};
   assign w_empty     = w_count == 2'd0;
   assign w_last      = r_init_ptr == ADDR_W'(DATA_DEPTH - 1);
   assign w_occ       = {1'b0, w_count} + {2'b00, r_inflight};
   // Ready depends only on registered state so consumer backpressure never
   // reaches the request side combinationally.
   assign req_ready_o = r_state == S_RUN && !r_flush_pending && w_occ < 3'd2;
   assign w_accept    = req_valid_i && req_ready_o;
   assign init_done_o = r_state == S_RUN;
   assign rsp_valid_o = !w_empty || r_inflight;
   // The FIFO head is always older than the in-flight word, so it goes first;
   // an in-flight word that the consumer does not take this cycle is parked.
   assign w_pop       = !w_empty && rsp_ready_i;
   assign w_push      = r_inflight && !(w_empty && rsp_ready_i);
   assign rsp_rdata_o = !w_empty ? w_head : r_inflight ? sram_rdata_i : '0;
   sram_rsp_fifo #(.W(DATA_WIDTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .data_i  (sram_rdata_i),
      .data_o  (w_head),
      .count_o (w_count)
   );
   // Sweep strobes are gated with rst_n so the port is quiet while reset is held.
   always_comb begin
      w_state_nxt  = r_state;
      sram_en_o    = 1'b0;
      sram_we_o    = '0;
      sram_addr_o  = w_req.addr;
      sram_wdata_o = w_req.wdata;
      if (r_state == S_INIT) begin
         sram_en_o    = rst_n;
         sram_we_o    = {NB{rst_n}};
         sram_addr_o  = r_init_ptr;
         sram_wdata_o = rst_n ? INIT_VALUE : '0;
         w_state_nxt  = w_last ? S_RUN : S_INIT;
      end else begin
         sram_en_o   = w_accept;
         sram_we_o   = w_accept ? w_req.we : '0;
         w_state_nxt = (r_flush_pending && !r_inflight && w_empty) ? S_INIT : S_RUN;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_INIT;
         r_init_ptr      <= '0;
         r_flush_pending <= 1'b0;
         r_inflight      <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_init_ptr      <= (r_state == S_INIT && !w_last) ? r_init_ptr + 1'b1 : '0;
         r_inflight      <= w_accept && w_req.we == '0;
         r_flush_pending <= r_state == S_RUN && w_state_nxt == S_RUN && (r_flush_pending || flush_i);
         assert (w_occ <= 3'd2);
      end
   end
endmodule

// File: tb/tb_sram_port_master.sv
// tb_sram_port_master: directed self-checking bench for sram_port_master with a behavioural SRAM.
module tb_sram_port_master;
   localparam int DW = 32, DEPTH = 16, AW = 4, NB = 4;
   logic          clk = 1'b0, rst_n;
   logic          req_valid, req_ready, rsp_valid, rsp_ready, flush, init_done, sram_en;
   logic [AW-1:0] req_addr, sram_addr;
   logic [NB-1:0] req_we, sram_we;
   logic [DW-1:0] req_wdata, rsp_rdata, sram_wdata, sram_rdata;
   logic [DW-1:0] mem [DEPTH];
   int            n_err = 0, n_chk = 0;
   sram_port_master #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .BYTE_SIZE(8), .INIT_VALUE('0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_addr_i   (req_addr),
      .req_we_i     (req_we),
      .req_wdata_i  (req_wdata),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_rdata_o  (rsp_rdata),
      .flush_i      (flush),
      .init_done_o  (init_done),
      .sram_en_o    (sram_en),
      .sram_we_o    (sram_we),
      .sram_addr_o  (sram_addr),
      .sram_wdata_o (sram_wdata),
      .sram_rdata_i (sram_rdata)
   );
   always #5 clk = ~clk;
   // Behavioural SRAM port: byte-lane writes, registered read data one cycle after en with we==0.
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we == '0) sram_rdata <= mem[sram_addr];
         for (int b = 0; b < NB; b++)
            if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic req(input logic v, input logic [AW-1:0] a, input logic [NB-1:0] we, input logic [DW-1:0] wd);
      req_valid = v;
      req_addr  = a;
      req_we    = we;
      req_wdata = wd;
      #1;
   endtask
   task automatic sweep(input string tag, input int flush_at);
      for (int c = 0; c < DEPTH; c++) begin
         if (c == flush_at) flush = 1'b1;
         chk({tag, "_en"}, 32'(sram_en), 32'd1);
         chk({tag, "_we"}, 32'(sram_we), 32'hF);
         chk({tag, "_addr"}, 32'(sram_addr), 32'(c));
         chk({tag, "_wdata"}, sram_wdata, 32'h0);
         chk({tag, "_busy_done"}, 32'(init_done), 32'd0);
         chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
         step;
         flush = 1'b0;
      end
      #1;
      chk({tag, "_done"}, 32'(init_done), 32'd1);
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
   endtask
   initial begin
      rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
      req_valid = 1'b0; req_addr = '0; req_we = '0; req_wdata = '0;
      step;
      step;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_done", 32'(init_done), 32'd0);
      chk("rst_en", 32'(sram_en), 32'd0);
      chk("rst_we", 32'(sram_we), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_wdata", sram_wdata, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      rst_n = 1'b1;
      #1;
      sweep("init", -1);
      // back-to-back reads
      req(1'b1, 4'd3, 4'h0, 32'h0);
      chk("b2b_ready0", 32'(req_ready), 32'd1);
      chk("b2b_en0", 32'(sram_en), 32'd1);
      chk("b2b_addr0", 32'(sram_addr), 32'd3);
      step;
      req(1'b1, 4'd7, 4'h0, 32'h0);
      chk("b2b_ready1", 32'(req_ready), 32'd1);
      chk("b2b_en1", 32'(sram_en), 32'd1);
      chk("b2b_valid0", 32'(rsp_valid), 32'd1);
      chk("b2b_data0", rsp_rdata, 32'h0);
      step;
      req(1'b0, 4'd0, 4'h0, 32'h0);
      chk("b2b_valid1", 32'(rsp_valid), 32'd1);
      chk("b2b_data1", rsp_rdata, 32'h0);
      chk("idle_en", 32'(sram_en), 32'd0);
      step;
      chk("b2b_idle", 32'(rsp_valid), 32'd0);
      // byte write then read
      req(1'b1, 4'd5, 4'b0010, 32'hAABBCCDD);
      chk("bw_en", 32'(sram_en), 32'd1);
      chk("bw_we", 32'(sram_we), 32'h2);
      chk("bw_wdata", sram_wdata, 32'hAABBCCDD);
      step;
      req(1'b1, 4'd5, 4'h0, 32'h0);
      chk("bw_rd_we", 32'(sram_we), 32'h0);
      step;
      req(1'b0, 4'd0, 4'h0, 32'h0);
      chk("bw_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bw_rsp_wrvalid", 32'(rsp_valid), 32'd1);
      chk("bw_rsp_data", rsp_rdata, 32'h0000CC00);
      step;
      chk("bw_no_wr_rsp", 32'(rsp_valid), 32'd0);
      // backpressure
      for (int i = 1; i <= 3; i++) begin
         req(1'b1, AW'(i), 4'hF, 32'(i * 32'h11));
         step;
      end
      rsp_ready = 1'b0;
      req(1'b1, 4'd1, 4'h0, 32'h0);
      chk("bp_ready0", 32'(req_ready), 32'd1);
      step;
      req(1'b1, 4'd2, 4'h0, 32'h0);
      chk("bp_ready1", 32'(req_ready), 32'd1);
      step;
      req(1'b1, 4'd3, 4'h0, 32'h0);
      chk("bp_ready2", 32'(req_ready), 32'd0);
      chk("bp_en2", 32'(sram_en), 32'd0);
      step;
      chk("bp_full_ready", 32'(req_ready), 32'd0);
      chk("bp_full_valid", 32'(rsp_valid), 32'd1);
      chk("bp_head", rsp_rdata, 32'h11);
      rsp_ready = 1'b1;
      #1;
      chk("bp_ready_no_comb", 32'(req_ready), 32'd0);
      chk("bp_rsp0", rsp_rdata, 32'h11);
      step;
      chk("bp_rsp1", rsp_rdata, 32'h22);
      chk("bp_ready3", 32'(req_ready), 32'd1);
      chk("bp_en3", 32'(sram_en), 32'd1);
      step;
      req(1'b0, 4'd0, 4'h0, 32'h0);
      chk("bp_valid2", 32'(rsp_valid), 32'd1);
      chk("bp_rsp2", rsp_rdata, 32'h33);
      step;
      chk("bp_drained", 32'(rsp_valid), 32'd0);
      // flush with one pending response
      rsp_ready = 1'b0;
      req(1'b1, 4'd5, 4'h0, 32'h0);
      step;
      req(1'b0, 4'd0, 4'h0, 32'h0);
      step;
      chk("fl_pend_valid", 32'(rsp_valid), 32'd1);
      chk("fl_pend_data", rsp_rdata, 32'h0000CC00);
      flush = 1'b1;
      step;
      flush = 1'b0;
      chk("fl_ready_blocked", 32'(req_ready), 32'd0);
      chk("fl_still_run", 32'(init_done), 32'd1);
      chk("fl_held_valid", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      step;
      chk("fl_popped", 32'(rsp_valid), 32'd0);
      chk("fl_ready_after_pop", 32'(req_ready), 32'd0);
      chk("fl_run_after_pop", 32'(init_done), 32'd1);
      step;
      sweep("flush", 3);
      req(1'b1, 4'd5, 4'h0, 32'h0);
      step;
      req(1'b0, 4'd0, 4'h0, 32'h0);
      chk("fl_rd_valid", 32'(rsp_valid), 32'd1);
      chk("fl_rd_cleared", rsp_rdata, 32'h0);
      step;
      // reset in the middle of a sweep
      flush = 1'b1;
      step;
      flush = 1'b0;
      chk("mr_ready_blocked", 32'(req_ready), 32'd0);
      step;
      chk("mr_in_init", 32'(init_done), 32'd0);
      for (int i = 0; i < 9; i++) step;
      chk("mr_addr9", 32'(sram_addr), 32'd9);
      rst_n = 1'b0;
      #1;
      chk("mr_en", 32'(sram_en), 32'd0);
      chk("mr_we", 32'(sram_we), 32'd0);
      chk("mr_addr", 32'(sram_addr), 32'd0);
      chk("mr_wdata", sram_wdata, 32'd0);
      chk("mr_done", 32'(init_done), 32'd0);
      chk("mr_ready", 32'(req_ready), 32'd0);
      chk("mr_valid", 32'(rsp_valid), 32'd0);
      chk("mr_rdata", rsp_rdata, 32'd0);
      step;
      rst_n = 1'b1;
      #1;
      sweep("resweep", -1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
